inst_fetch_wb_master: RTL and testbench
=======================================

Name: inst_fetch_wb_master

Overview:
- Wishbone B3 classic single-read bus master on the instruction side.
- Takes fetch requests (PC, chip enable) from the IF stage and runs one Wishbone read per instruction toward the instruction ROM/slave.
- Returns the byte-swapped 32-bit instruction to the pipeline and holds the pipeline via a stall request until the bus acknowledges.
- Handles pipeline flush, external stall, and a bus-timeout fallback.

Parameters:
- TIMEOUT, 255, max cycles in BUSY without wb_ack_i before abort (1..255, 8-bit counter).
- NOP_WORD, 32'h00000013, instruction returned on timeout/error (RISC-V addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cpu_ce_i  input  1  fetch request valid from IF stage.
- cpu_addr_i  input  32  fetch PC; bits [1:0] ignored.
- stall_i  input  1  pipeline stall from ctrl (IF stage frozen).
- flush_i  input  1  pipeline flush; cancels the outstanding fetch.
- cpu_inst_o  output  32  fetched instruction, byte-swapped.
- stallreq_o  output  1  request to ctrl to stall the pipeline while a fetch is pending.
- wb_adr_o  output  32  Wishbone address, word-aligned.
- wb_cyc_o  output  1  Wishbone cycle.
- wb_stb_o  output  1  Wishbone strobe.
- wb_we_o  output  1  always 0 (read-only master).
- wb_sel_o  output  4  always 4'b1111 during a cycle, 0 otherwise.
- wb_dat_i  input  32  read data, little-endian byte order.
- wb_ack_i  input  1  slave acknowledge.
- wb_err_i  input  1  slave error; treated like ack with NOP_WORD data.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; wb_cyc_o=wb_stb_o=0; wb_adr_o=0; wb_sel_o=0.
  - rd_buf=0; timeout counter=0.
  - cpu_inst_o=0; stallreq_o=0.
- Byte swap: swap(d) = {d[7:0], d[15:8], d[23:16], d[31:24]}.
- States: IDLE, BUSY, WAIT_FOR_STALL.
- IDLE:
  - If flush_i=1: stay IDLE.
  - Else if cpu_ce_i=1:
    - Register wb_adr_o={cpu_addr_i[31:2],2'b00}.
    - Set wb_cyc_o=wb_stb_o=1, wb_sel_o=4'b1111, counter=0.
    - Next state BUSY.
  - stallreq_o is combinational: 1 when cpu_ce_i=1 and flush_i=0.
  - cpu_inst_o=rd_buf.
- BUSY:
  - stallreq_o=1 unless terminated this cycle.
  - flush_i=1 (priority over ack/err/timeout):
    - Drop cyc/stb/sel next edge; return to IDLE; rd_buf unchanged.
    - stallreq_o=0; cpu_inst_o=0.
  - wb_ack_i=1:
    - rd_buf<=swap(wb_dat_i); drop cyc/stb/sel.
    - stallreq_o=0 and cpu_inst_o=swap(wb_dat_i) combinationally in the same cycle.
    - Next state WAIT_FOR_STALL if stall_i=1, else IDLE.
  - wb_err_i=1, or counter reaches TIMEOUT-1 with no ack:
    - Same as ack, but with data NOP_WORD (not swapped).
  - Otherwise: hold all bus outputs stable; counter+1.
  - ack and err in the same cycle: ack wins.
- WAIT_FOR_STALL:
  - Bus idle; cpu_inst_o=rd_buf; stallreq_o=0.
  - Go to IDLE when stall_i=0 or flush_i=1.
- Latency: request in IDLE at edge N puts the cycle on the bus from N+1. With a zero-wait slave (ack in the first BUSY cycle), the instruction is valid in that cycle, so 1 stall cycle per fetch.
- Back-to-back fetches: one IDLE cycle is required between Wishbone cycles, so cyc deasserts for at least 1 cycle.
- cpu_ce_i dropping while BUSY does not abort the cycle; only flush_i aborts.
- Address and data widths are fixed at 32; the counter saturates and never wraps while BUSY.
- Reset asserted mid-cycle: cyc/stb drop immediately (asynchronous) and outputs return to reset values.

Test Plan:
- Reset then single fetch:
  - Stimulus: cpu_ce_i=1, cpu_addr_i=0x0000_0004; slave acks on the 1st BUSY cycle with wb_dat_i=0x1305_0000.
  - Required: wb_adr_o=0x4, sel=F, we=0; cpu_inst_o=0x0000_0513 in the ack cycle; stallreq_o high exactly 1 cycle before ack.
- Wait states:
  - Stimulus: slave delays ack by 3 cycles, data 0xB305_B500.
  - Required: wb_adr_o/cyc/stb stable for 4 BUSY cycles; stallreq_o=1 throughout; result 0x00B5_05B3.
- Flush during BUSY:
  - Stimulus: assert flush_i on the 2nd BUSY cycle, before ack.
  - Required: cyc/stb=0 next cycle; state IDLE; rd_buf retains its prior value; a late ack is ignored.
- Stall on completion:
  - Stimulus: stall_i=1 at the ack cycle, held 3 cycles.
  - Required: WAIT_FOR_STALL for 3 cycles; cpu_inst_o stable at the swapped word; no new cyc until stall_i=0.
- Timeout:
  - Stimulus: TIMEOUT=4, slave never acks.
  - Required: cycle terminates after 4 BUSY cycles; cpu_inst_o=0x0000_0013; stallreq_o=0; state IDLE.
- Async reset mid-cycle:
  - Stimulus: rst=0 between clock edges while BUSY.
  - Required: wb_cyc_o=wb_stb_o=0 and cpu_inst_o=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/inst_fetch_wb_master.sv
// inst_fetch_wb_master: Wishbone B3 classic single-read instruction fetch master
// with flush, stall hand-off and bus-timeout fallback to a NOP.
module inst_fetch_wb_master #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] cpu_inst_o,
    output logic        stallreq_o,
    output logic [31:0] wb_adr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);
    typedef enum logic [1:0] {IDLE, BUSY, WAIT_FOR_STALL} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_adr, r_buf, w_swap, w_tdata, w_inst;
    logic [7:0]  r_cnt;
    logic        r_cyc, w_start, w_end, w_load, w_stallreq, w_term;
    assign w_swap  = {wb_dat_i[7:0], wb_dat_i[15:8], wb_dat_i[23:16], wb_dat_i[31:24]};
    // ack outranks err and timeout; both fallbacks deliver the NOP
    assign w_term  = wb_ack_i | wb_err_i | (r_cnt == 8'(TIMEOUT - 1));
    assign w_tdata = wb_ack_i ? w_swap : NOP_WORD;
    assign wb_adr_o   = r_adr;
    assign wb_cyc_o   = r_cyc;
    assign wb_stb_o   = r_cyc;
    assign wb_we_o    = 1'b0;
    assign wb_sel_o   = r_cyc ? 4'hF : 4'h0;
    assign cpu_inst_o = w_inst;
    assign stallreq_o = rst & w_stallreq;
    always_comb begin
        w_next     = r_state;
        w_stallreq = 1'b0;
        w_inst     = r_buf;
        w_start    = 1'b0;
        w_end      = 1'b0;
        w_load     = 1'b0;
        case (r_state)
            IDLE: begin
                w_stallreq = cpu_ce_i & ~flush_i;
                w_start    = cpu_ce_i & ~flush_i;
                w_next     = w_start ? BUSY : IDLE;
            end
            BUSY: begin
                if (flush_i) begin
                    w_inst = '0;
                    w_end  = 1'b1;
                    w_next = IDLE;
                end else if (w_term) begin
                    w_inst = w_tdata;
                    w_end  = 1'b1;
                    w_load = 1'b1;
                    w_next = stall_i ? WAIT_FOR_STALL : IDLE;
                end else begin
                    w_stallreq = 1'b1;
                end
            end
            WAIT_FOR_STALL: w_next = (!stall_i || flush_i) ? IDLE : WAIT_FOR_STALL;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_adr   <= '0;
            r_cyc   <= 1'b0;
            r_buf   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_adr <= cpu_addr_i & ~32'h3;
                r_cyc <= 1'b1;
                r_cnt <= '0;
            end else if (w_end) begin
                r_cyc <= 1'b0;
            end else if (r_cyc && r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_load) r_buf <= w_tdata;
        end
    end
endmodule

// File: tb/tb_inst_fetch_wb_master.sv
// tb_inst_fetch_wb_master: randomized fetches against a transaction-level model
// of the instruction fetch Wishbone master.
module tb_inst_fetch_wb_master;
    localparam int unsigned TO = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 1'b0, rst = 1'b0;
    logic        cpu_ce_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
    logic [31:0] cpu_addr_i = '0, wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
    logic [31:0] cpu_inst_o, wb_adr_o;
    logic        stallreq_o, wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] m_buf = '0;
    int          checks = 0, errors = 0;

    inst_fetch_wb_master #(.TIMEOUT(TO), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i),
        .stall_i(stall_i), .flush_i(flush_i), .cpu_inst_o(cpu_inst_o),
        .stallreq_o(stallreq_o), .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_swap(input logic [31:0] d);
        return ((d >> 24) & 32'hFF) | ((d >> 8) & 32'hFF00) | ((d << 8) & 32'hFF_0000) | (d << 24);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 ack, 1 err, 2 timeout, 3 ack+err together
    task automatic run_fetch(input logic [31:0] addr, input logic [31:0] data,
                             input int waits, input int stalls, input int kind);
        logic [31:0] wa, exp_i;
        int nw;
        wa    = addr & 32'hFFFF_FFFC;
        exp_i = (kind == 0 || kind == 3) ? model_swap(data) : NOP;
        nw    = (kind == 2) ? int'(TO) - 1 : waits;
        cpu_ce_i = 1'b1;
        cpu_addr_i = addr;
        #1;
        checks++;
        if ({stallreq_o, wb_cyc_o} !== 2'b10) begin
            errors++;
            $display("FAIL idle_req got stallreq=%b cyc=%b exp 1 0", stallreq_o, wb_cyc_o);
        end
        tick();
        cpu_ce_i = 1'b0;
        cpu_addr_i = $urandom;
        for (int i = 0; i < nw; i++) begin
            wb_dat_i = $urandom;
            #1;
            checks++;
            if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, stallreq_o, wb_adr_o} !== {3'b110, 4'hF, 1'b1, wa}) begin
                errors++;
                $display("FAIL busy_hold cyc=%b stb=%b we=%b sel=%h stallreq=%b adr=%h exp 1 1 0 f 1 %h",
                         wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, stallreq_o, wb_adr_o, wa);
            end
            tick();
        end
        wb_ack_i = (kind == 0 || kind == 3);
        wb_err_i = (kind == 1 || kind == 3);
        wb_dat_i = data;
        stall_i  = stalls > 0;
        #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, stallreq_o, wb_adr_o} !== {3'b110, 4'hF, 1'b0, wa}
            || cpu_inst_o !== exp_i) begin
            errors++;
            $display("FAIL done_cycle cyc=%b stallreq=%b adr=%h inst=%h exp 1 0 %h %h",
                     wb_cyc_o, stallreq_o, wb_adr_o, cpu_inst_o, wa, exp_i);
        end
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = $urandom;
        m_buf = exp_i;
        for (int s = 0; s < stalls; s++) begin
            stall_i = s < stalls - 1;
            cpu_ce_i = 1'b1;
            cpu_addr_i = $urandom;
            #1;
            checks++;
            if ({wb_cyc_o, stallreq_o} !== 2'b00 || cpu_inst_o !== m_buf) begin
                errors++;
                $display("FAIL wait_stall cyc=%b stallreq=%b inst=%h exp 0 0 %h",
                         wb_cyc_o, stallreq_o, cpu_inst_o, m_buf);
            end
            tick();
        end
        cpu_ce_i = 1'b0;
        stall_i = 1'b0;
        #1;
        checks++;
        if ({wb_cyc_o, wb_sel_o, stallreq_o} !== 6'b0 || cpu_inst_o !== m_buf) begin
            errors++;
            $display("FAIL idle_after cyc=%b sel=%h stallreq=%b inst=%h exp 0 0 0 %h",
                     wb_cyc_o, wb_sel_o, stallreq_o, cpu_inst_o, m_buf);
        end
        tick();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, stallreq_o} !== 8'b0 || wb_adr_o !== 32'h0
            || cpu_inst_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_state cyc=%b stb=%b sel=%h stallreq=%b adr=%h inst=%h exp all zero",
                     wb_cyc_o, wb_stb_o, wb_sel_o, stallreq_o, wb_adr_o, cpu_inst_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_single_fetch();
        run_fetch(32'h0000_0004, 32'h1305_0000, 0, 0, 0);
        checks++;
        if (m_buf !== 32'h0000_0513 || cpu_inst_o !== 32'h0000_0513) begin
            errors++;
            $display("FAIL single_fetch inst=%h exp 00000513", cpu_inst_o);
        end
    endtask

    task automatic test_wait_states();
        run_fetch(32'h0000_0103, 32'hB305_B500, 3, 0, 0);
        checks++;
        if (cpu_inst_o !== 32'h00B5_05B3) begin
            errors++;
            $display("FAIL wait_states inst=%h exp 00b505b3", cpu_inst_o);
        end
    endtask

    task automatic test_flush();
        flush_i = 1'b1;
        cpu_ce_i = 1'b1;
        cpu_addr_i = 32'h40;
        #1;
        checks++;
        if (stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_req stallreq=%b exp 0", stallreq_o);
        end
        tick();
        flush_i = 1'b0;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b0 || stallreq_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle_stay cyc=%b stallreq=%b exp 0 1", wb_cyc_o, stallreq_o);
        end
        tick();
        cpu_ce_i = 1'b0;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b1 || stallreq_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_busy1 cyc=%b stallreq=%b exp 1 1", wb_cyc_o, stallreq_o);
        end
        tick();
        flush_i = 1'b1;
        #1;
        checks++;
        if (stallreq_o !== 1'b0 || cpu_inst_o !== 32'h0 || wb_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_busy2 stallreq=%b inst=%h cyc=%b exp 0 0 1", stallreq_o, cpu_inst_o, wb_cyc_o);
        end
        tick();
        flush_i = 1'b0;
        wb_ack_i = 1'b1;
        wb_dat_i = $urandom;
        #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_sel_o, stallreq_o} !== 7'b0 || cpu_inst_o !== m_buf) begin
            errors++;
            $display("FAIL flush_drop cyc=%b stb=%b stallreq=%b inst=%h exp 0 0 0 %h",
                     wb_cyc_o, wb_stb_o, stallreq_o, cpu_inst_o, m_buf);
        end
        tick();
        wb_ack_i = 1'b0;
        #1;
        checks++;
        if (cpu_inst_o !== m_buf || wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_late_ack inst=%h cyc=%b exp %h 0", cpu_inst_o, wb_cyc_o, m_buf);
        end
        tick();
    endtask

    task automatic test_stall();
        run_fetch(32'h0000_0020, 32'hDEAD_BEEF, 0, 3, 0);
        run_fetch(32'h0000_0024, 32'h0102_0304, 2, 1, 0);
    endtask

    task automatic test_timeout();
        run_fetch(32'h0000_0080, 32'h1234_5678, 0, 0, 2);
        run_fetch(32'h0000_0084, 32'h1111_2222, 0, 2, 2);
    endtask

    task automatic test_err();
        run_fetch(32'h0000_0090, 32'hAAAA_5555, 1, 0, 1);
        run_fetch(32'h0000_0094, 32'h8877_6655, 0, 0, 3);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++)
            run_fetch($urandom, $urandom, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    endtask

    task automatic test_async_reset();
        cpu_ce_i = 1'b1;
        cpu_addr_i = 32'h0000_0F00;
        tick();
        cpu_ce_i = 1'b0;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL arst_busy cyc=%b exp 1", wb_cyc_o);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_sel_o, stallreq_o} !== 7'b0 || cpu_inst_o !== 32'h0 || wb_adr_o !== 32'h0) begin
            errors++;
            $display("FAIL arst_mid cyc=%b stb=%b sel=%h stallreq=%b inst=%h adr=%h exp all zero",
                     wb_cyc_o, wb_stb_o, wb_sel_o, stallreq_o, cpu_inst_o, wb_adr_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_buf = '0;
        #1;
        checks++;
        if (cpu_inst_o !== 32'h0 || wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL arst_after inst=%h cyc=%b exp 0 0", cpu_inst_o, wb_cyc_o);
        end
        tick();
        run_fetch(32'h0000_0008, 32'h9300_1000, 1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_wait_states();
        test_flush();
        test_stall();
        test_timeout();
        test_err();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
